// File: rtl/psum_pkg.sv
// Shared types, widths and lane arithmetic for the partial-sum write-back stage.
package psum_pkg;

  localparam int unsigned DEPTH  = 2048;
  localparam int unsigned LANES  = 8;
  localparam int unsigned LANE_W = 16;
  localparam int unsigned ROW_W  = LANES * LANE_W;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  localparam logic signed [LANE_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [LANE_W-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    IDLE,
    OVR,
    RD,
    WR,
    DONE
  } state_t;

  // Signed lane add clamped to the 16-bit range; overflow shows as disagreeing top bits.
  function automatic logic [LANE_W-1:0] sat_add(input logic [LANE_W-1:0] x,
                                                input logic [LANE_W-1:0] y);
    logic [LANE_W:0] s;
    s = {x[LANE_W-1], x} + {y[LANE_W-1], y};
    if (s[LANE_W] != s[LANE_W-1]) begin
      sat_add = s[LANE_W] ? SAT_MIN : SAT_MAX;
    end else begin
      sat_add = s[LANE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/lane_sat_add_relu.sv
// Lane-wise saturating add (or pass-through of b) followed by optional ReLU.
module lane_sat_add_relu
  import psum_pkg::*;
(
  input  logic [ROW_W-1:0] a,
  input  logic [ROW_W-1:0] b,
  input  logic             add_en,
  input  logic             relu_en,
  output logic [ROW_W-1:0] y
);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LANE_W-1:0] la;
    logic [LANE_W-1:0] lb;
    logic [LANE_W-1:0] sum;

    assign la  = a[g*LANE_W +: LANE_W];
    assign lb  = b[g*LANE_W +: LANE_W];
    assign sum = add_en ? sat_add(la, lb) : lb;
    assign y[g*LANE_W +: LANE_W] = (relu_en && sum[LANE_W-1]) ? '0 : sum;
  end

endmodule

// File: rtl/psum_accum_writer.sv
// Write-back of partial-sum rows into the output SRAM, overwriting or accumulating
// via read-modify-write, with optional ReLU; SRAM pins are decoded from state.
module psum_accum_writer
  import psum_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_rows,
  input  logic              acc_en,
  input  logic              relu_en,
  input  logic              in_valid,
  input  logic [ROW_W-1:0]  in_data,
  output logic              in_ready,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  output logic [ROW_W-1:0]  sram_d,
  input  logic [ROW_W-1:0]  sram_q,
  output logic              busy,
  output logic              done
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic [CNT_W-1:0]  rows_left, rows_left_nx;
  logic [ROW_W-1:0]  hold_reg, hold_nx;
  logic              relu_mode, relu_nx;

  logic              add_en;
  logic [ROW_W-1:0]  b_row;
  logic [ROW_W-1:0]  row_out;

  // Only the WR state accumulates; OVR passes the incoming row straight through.
  assign add_en = (state == WR);
  assign b_row  = add_en ? hold_reg : in_data;

  lane_sat_add_relu u_lane (
    .a      (sram_q),
    .b      (b_row),
    .add_en (add_en),
    .relu_en(relu_mode),
    .y      (row_out)
  );

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      addr      <= '0;
      rows_left <= '0;
      hold_reg  <= '0;
      relu_mode <= 1'b0;
    end else begin
      state     <= state_nx;
      addr      <= addr_nx;
      rows_left <= rows_left_nx;
      hold_reg  <= hold_nx;
      relu_mode <= relu_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    addr_nx      = addr;
    rows_left_nx = rows_left;
    hold_nx      = hold_reg;
    relu_nx      = relu_mode;
    in_ready     = 1'b0;
    sram_cen     = 1'b1;
    sram_wen     = 1'b1;
    sram_a       = '0;
    sram_d       = '0;

    case (state)
      IDLE: begin
        if (start) begin
          addr_nx      = base_addr;
          rows_left_nx = num_rows;
          relu_nx      = relu_en;
          if (num_rows == '0) begin
            state_nx = DONE;
          end else if (acc_en) begin
            state_nx = RD;
          end else begin
            state_nx = OVR;
          end
        end
      end

      OVR: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sram_cen     = 1'b0;
          sram_wen     = 1'b0;
          sram_a       = addr;
          sram_d       = row_out;
          addr_nx      = addr + ADDR_W'(1);
          rows_left_nx = rows_left - CNT_W'(1);
          if (rows_left == CNT_W'(1)) begin
            state_nx = DONE;
          end
        end
      end

      RD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hold_nx  = in_data;
          sram_cen = 1'b0;
          sram_a   = addr;
          state_nx = WR;
        end
      end

      // sram_q holds the word read on the previous edge.
      WR: begin
        sram_cen     = 1'b0;
        sram_wen     = 1'b0;
        sram_a       = addr;
        sram_d       = row_out;
        addr_nx      = addr + ADDR_W'(1);
        rows_left_nx = rows_left - CNT_W'(1);
        state_nx     = (rows_left == CNT_W'(1)) ? DONE : RD;
      end

      DONE: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
